riscv_mem: RTL

- Memory-access pipeline stage, directly downstream of the execute stage.
- Consumes the EX result, memory function, store data and writeback register.
- Performs byte/half/word loads and stores over a single-outstanding data-bus request/ack interface.
- Delivers a registered writeback packet to the WB stage.

---
 rtl/riscv_mem.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_mem.sv
`default_nettype none
// ============================================================================
// riscv_mem : memory-access pipeline stage (byte/half/word loads and stores
//             over a single-outstanding request/ack data bus)
// Revision  : 1.0
// ============================================================================
module riscv_mem #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MEM_FUNCT_W    = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_rdy,
  output logic                   in_ack,
  input  logic [31:0]            ex_mem_result,
  input  logic [MEM_FUNCT_W-1:0] ex_mem_funct,
  input  logic [31:0]            ex_mem_data,
  input  logic [4:0]             ex_mem_wb_rsd,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [31:0]            dmem_addr,
  output logic [3:0]             dmem_sel,
  output logic [31:0]            dmem_wdata,
  input  logic                   dmem_ack,
  input  logic                   dmem_err,
  input  logic [31:0]            dmem_rdata,
  output logic                   out_rdy,
  input  logic                   out_ack,
  output logic [31:0]            mem_wb_result,
  output logic [4:0]             mem_wb_rsd,
  output logic                   mem_wb_we,
  output logic [1:0]             mem_wb_exc
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [MEM_FUNCT_W-1:0] F_LB  = MEM_FUNCT_W'(1);
  localparam logic [MEM_FUNCT_W-1:0] F_LH  = MEM_FUNCT_W'(2);
  localparam logic [MEM_FUNCT_W-1:0] F_LW  = MEM_FUNCT_W'(3);
  localparam logic [MEM_FUNCT_W-1:0] F_LBU = MEM_FUNCT_W'(4);
  localparam logic [MEM_FUNCT_W-1:0] F_LHU = MEM_FUNCT_W'(5);
  localparam logic [MEM_FUNCT_W-1:0] F_SB  = MEM_FUNCT_W'(6);
  localparam logic [MEM_FUNCT_W-1:0] F_SH  = MEM_FUNCT_W'(7);
  localparam logic [MEM_FUNCT_W-1:0] F_SW  = MEM_FUNCT_W'(8);

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] EXC_NONE  = 2'd0;
  localparam logic [1:0] EXC_ALIGN = 2'd1;
  localparam logic [1:0] EXC_BUS   = 2'd2;
  localparam logic [1:0] EXC_TO    = 2'd3;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUS = 1'b1} state_t;

  typedef struct packed {
    logic       ld;
    logic       st;
    logic       sx;
    logic [1:0] sz;
  } op_t;

  function automatic op_t decode(input logic [MEM_FUNCT_W-1:0] f);
    op_t o;
    o = '0;
    case (f)
      F_LB:    begin o.ld = 1'b1; o.sx = 1'b1; o.sz = SZ_B; end
      F_LH:    begin o.ld = 1'b1; o.sx = 1'b1; o.sz = SZ_H; end
      F_LW:    begin o.ld = 1'b1;              o.sz = SZ_W; end
      F_LBU:   begin o.ld = 1'b1;              o.sz = SZ_B; end
      F_LHU:   begin o.ld = 1'b1;              o.sz = SZ_H; end
      F_SB:    begin o.st = 1'b1;              o.sz = SZ_B; end
      F_SH:    begin o.st = 1'b1;              o.sz = SZ_H; end
      F_SW:    begin o.st = 1'b1;              o.sz = SZ_W; end
      default: o = '0;
    endcase
    return o;
  endfunction

  state_t           state, state_nxt;
  op_t              req_op, req_op_nxt;
  logic [31:0]      req_addr, req_addr_nxt;
  logic [4:0]       req_rsd, req_rsd_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic             out_rdy_nxt, wb_we_nxt, dreq_nxt, dwe_nxt;
  logic [31:0]      wb_result_nxt, daddr_nxt, dwdata_nxt;
  logic [4:0]       wb_rsd_nxt;
  logic [1:0]       wb_exc_nxt;
  logic [3:0]       dsel_nxt;

  op_t              acc_op;
  logic             accept, misalign;
  logic [3:0]       acc_sel;
  logic [31:0]      acc_wdata, load_val;
  logic [7:0]       byte_lane;
  logic [15:0]      half_lane;

  assign in_ack = (state != ST_BUS) && (!out_rdy || out_ack);
  assign accept = in_rdy && in_ack;

  // Lane generation and alignment check for the packet currently offered by EX
  always_comb begin
    acc_op    = decode(ex_mem_funct);
    acc_sel   = 4'b1111;
    acc_wdata = ex_mem_data;
    case (acc_op.sz)
      SZ_B: begin
        acc_sel   = 4'b0001 << ex_mem_result[1:0];
        acc_wdata = {4{ex_mem_data[7:0]}};
      end
      SZ_H: begin
        acc_sel   = ex_mem_result[1] ? 4'b1100 : 4'b0011;
        acc_wdata = {2{ex_mem_data[15:0]}};
      end
      default: begin
        acc_sel   = 4'b1111;
        acc_wdata = ex_mem_data;
      end
    endcase
    misalign = (acc_op.ld || acc_op.st) &&
               (((acc_op.sz == SZ_H) && ex_mem_result[0]) ||
                ((acc_op.sz == SZ_W) && (ex_mem_result[1:0] != 2'b00)));
  end

  always_comb begin
    byte_lane = dmem_rdata[{req_addr[1:0], 3'b000} +: 8];
    half_lane = dmem_rdata[{req_addr[1], 4'b0000} +: 16];
    case (req_op.sz)
      SZ_B:    load_val = req_op.sx ? {{24{byte_lane[7]}}, byte_lane} : {24'd0, byte_lane};
      SZ_H:    load_val = req_op.sx ? {{16{half_lane[15]}}, half_lane} : {16'd0, half_lane};
      default: load_val = dmem_rdata;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    req_op_nxt    = req_op;
    req_addr_nxt  = req_addr;
    req_rsd_nxt   = req_rsd;
    cnt_nxt       = cnt;
    out_rdy_nxt   = out_rdy;
    wb_result_nxt = mem_wb_result;
    wb_rsd_nxt    = mem_wb_rsd;
    wb_we_nxt     = mem_wb_we;
    wb_exc_nxt    = mem_wb_exc;
    dreq_nxt      = dmem_req;
    dwe_nxt       = dmem_we;
    daddr_nxt     = dmem_addr;
    dsel_nxt      = dmem_sel;
    dwdata_nxt    = dmem_wdata;

    if (out_rdy && out_ack)
      out_rdy_nxt = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!(acc_op.ld || acc_op.st)) begin
            out_rdy_nxt   = 1'b1;
            wb_result_nxt = ex_mem_result;
            wb_rsd_nxt    = ex_mem_wb_rsd;
            wb_we_nxt     = (ex_mem_wb_rsd != 5'd0);
            wb_exc_nxt    = EXC_NONE;
          end else if (misalign) begin
            out_rdy_nxt   = 1'b1;
            wb_result_nxt = ex_mem_result;
            wb_rsd_nxt    = ex_mem_wb_rsd;
            wb_we_nxt     = 1'b0;
            wb_exc_nxt    = EXC_ALIGN;
          end else begin
            state_nxt    = ST_BUS;
            req_op_nxt   = acc_op;
            req_addr_nxt = ex_mem_result;
            req_rsd_nxt  = ex_mem_wb_rsd;
            cnt_nxt      = '0;
            dreq_nxt     = 1'b1;
            dwe_nxt      = acc_op.st;
            daddr_nxt    = {ex_mem_result[31:2], 2'b00};
            dsel_nxt     = acc_sel;
            dwdata_nxt   = acc_wdata;
          end
        end
      end
      ST_BUS: begin
        // err takes precedence over a simultaneous ack
        if (dmem_err || dmem_ack || (TO_EN && (cnt == CNT_LAST))) begin
          state_nxt     = ST_IDLE;
          dreq_nxt      = 1'b0;
          out_rdy_nxt   = 1'b1;
          wb_rsd_nxt    = req_rsd;
          wb_result_nxt = req_addr;
          wb_we_nxt     = 1'b0;
          if (dmem_err) begin
            wb_exc_nxt = EXC_BUS;
          end else if (dmem_ack) begin
            wb_exc_nxt = EXC_NONE;
            if (req_op.ld) begin
              wb_result_nxt = load_val;
              wb_we_nxt     = (req_rsd != 5'd0);
            end
          end else begin
            wb_exc_nxt = EXC_TO;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      req_op        <= '0;
      req_addr      <= '0;
      req_rsd       <= '0;
      cnt           <= '0;
      out_rdy       <= 1'b0;
      mem_wb_result <= '0;
      mem_wb_rsd    <= '0;
      mem_wb_we     <= 1'b0;
      mem_wb_exc    <= '0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_sel      <= '0;
      dmem_wdata    <= '0;
    end else begin
      state         <= state_nxt;
      req_op        <= req_op_nxt;
      req_addr      <= req_addr_nxt;
      req_rsd       <= req_rsd_nxt;
      cnt           <= cnt_nxt;
      out_rdy       <= out_rdy_nxt;
      mem_wb_result <= wb_result_nxt;
      mem_wb_rsd    <= wb_rsd_nxt;
      mem_wb_we     <= wb_we_nxt;
      mem_wb_exc    <= wb_exc_nxt;
      dmem_req      <= dreq_nxt;
      dmem_we       <= dwe_nxt;
      dmem_addr     <= daddr_nxt;
      dmem_sel      <= dsel_nxt;
      dmem_wdata    <= dwdata_nxt;
    end
  end

endmodule
`default_nettype wire
